uart_fb_write_ctrl: RTL and testbench

Sequencing and arbitration controller between the UART receiver and the single-port TFT frame-buffer RAM. It pairs received bytes into RGB565 pixels (high byte first), places them at sequential frame-buffer addresses with wrap-around, and shares the one RAM port between these pixel writes and the display scan-out reads. Display reads always win the port. Writes are buffered so that no pixel is lost while the display is blanking.

---
 rtl/uart_fb_write_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_fb_write_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fb_write_ctrl.sv
// uart_fb_write_ctrl: pairs UART bytes into RGB565 pixels and shares one frame-buffer RAM port
// between display reads (always win) and buffered pixel writes; UART_FB_TIMEOUT_EN adds the low-byte timeout.
module uart_fb_write_ctrl #(
    parameter int FB_DEPTH    = 131072,
    parameter int ADDR_W      = 17,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              addr_clr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              rd_valid,
    output logic              frame_done,
    output logic              overflow,
    output logic              byte_err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    if ((64'd1 << ADDR_W) < 64'(FB_DEPTH) || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("uart_fb_write_ctrl: ADDR_W too small for FB_DEPTH or TIMEOUT_CYC < 1");
    end

    typedef enum logic {HI, LO} state_t;
    state_t state;
    logic [7:0] hi_byte;
    logic [15:0] pix;
    logic pixel_ready, timed_out, load_hi;

    // A byte arriving in the timeout cycle starts a fresh pixel instead of completing the stale one
    assign load_hi = rx_done && (state == HI || timed_out);

`ifdef UART_FB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt;

    // byte_err is high exactly while idle_cnt holds TIMEOUT_CYC, so it doubles as the timeout flag
    assign timed_out = byte_err;

    always_ff @(posedge Clk) begin
        if (Reset || addr_clr) begin
            idle_cnt <= '0;
            byte_err <= 1'b0;
        end else if (load_hi) begin
            idle_cnt <= CNT_W'(1);
            byte_err <= TIMEOUT_CYC == 1;
        end else if (state == LO && !rx_done && !timed_out) begin
            idle_cnt <= idle_cnt + 1'b1;
            byte_err <= idle_cnt == CNT_W'(TIMEOUT_CYC - 1);
        end else begin
            idle_cnt <= '0;
            byte_err <= 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign byte_err  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        pixel_ready <= 1'b0;
        if (Reset || addr_clr) begin
            state   <= HI;
            hi_byte <= '0;
        end else if (load_hi) begin
            state   <= LO;
            hi_byte <= rx_data;
        end else if (rx_done) begin
            state       <= HI;
            pix         <= {hi_byte, rx_data};
            pixel_ready <= 1'b1;
        end else if (timed_out) begin
            state <= HI;
        end
    end

    logic pend, wr_issue;
    logic [15:0] pend_data, last_wdata;
    logic [ADDR_W-1:0] pend_addr, wr_addr, wr_next, last_addr;

    assign wr_issue  = pend && !rd_req;
    assign wr_next   = wr_addr == LAST_ADDR ? '0 : wr_addr + 1'b1;
    assign ram_en    = rd_req || pend;
    assign ram_we    = wr_issue;
    assign ram_addr  = rd_req ? rd_addr : pend ? pend_addr : last_addr;
    assign ram_wdata = wr_issue ? pend_data : last_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend       <= 1'b0;
            pend_data  <= '0;
            pend_addr  <= '0;
            wr_addr    <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
            rd_valid   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rd_valid   <= rd_req;
            frame_done <= wr_issue && pend_addr == LAST_ADDR;
            last_addr  <= ram_addr;
            last_wdata <= ram_wdata;
            // A pixel that finds the entry still blocked is dropped, but its address slot is consumed
            if (addr_clr) begin
                pend    <= 1'b0;
                wr_addr <= '0;
            end else if (pixel_ready) begin
                wr_addr <= wr_next;
                if (pend && rd_req) begin
                    overflow <= 1'b1;
                end else begin
                    pend      <= 1'b1;
                    pend_data <= pix;
                    pend_addr <= wr_addr;
                end
            end else if (wr_issue) begin
                pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_fb_write_ctrl.sv
// tb_uart_fb_write_ctrl: directed stimulus with a scoreboard of expected RAM writes, frame_done
// and byte_err pulses (with their exact cycles), checked by a negedge monitor.
module tb_uart_fb_write_ctrl;
    localparam int FB_DEPTH = 16, ADDR_W = 5, TIMEOUT_CYC = 100;

    logic Clk = 1'b0, Reset = 1'b1, rx_done = 1'b0, addr_clr = 1'b0, rd_req = 1'b0;
    logic [7:0] rx_data = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic ram_en, ram_we, rd_valid, frame_done, overflow, byte_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0] ram_wdata;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        int                c;
    } wr_t;
    wr_t wq[$];
    wr_t e_w;
    int fq[$], bq[$];
    int cyc = 0, n_vec = 0, n_err = 0, e_c;
    logic done = 1'b0, ovf_known = 1'b1, exp_ovf = 1'b0, prev_rd = 1'b0, prev_rst = 1'b1;

    uart_fb_write_ctrl #(.FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .Clk(Clk), .Reset(Reset), .rx_done(rx_done), .rx_data(rx_data), .addr_clr(addr_clr),
        .rd_req(rd_req), .rd_addr(rd_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .rd_valid(rd_valid), .frame_done(frame_done), .overflow(overflow),
        .byte_err(byte_err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic pixel(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        int lo;
        send(d[15:8]);
        lo = cyc;
        send(d[7:0]);
        wq.push_back('{a, d, lo + 2});
        if (a == ADDR_W'(FB_DEPTH - 1)) fq.push_back(lo + 3);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (cyc >= 1) begin
            if (Reset && prev_rst)
                chk("reset_outputs", 64'({ram_en, ram_we, ram_addr, ram_wdata, rd_valid, frame_done, overflow, byte_err}), 64'd0);
            chk("rd_valid", 64'(rd_valid), 64'(prev_rd && !prev_rst));
            if (rd_req) chk("read_port", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, rd_addr}));
            if (ovf_known) chk("overflow", 64'(overflow), 64'(exp_ovf));
            if (ram_we) begin
                if (wq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected (cycle %0d)", ram_addr, ram_wdata, cyc);
                end else begin
                    e_w = wq.pop_front();
                    chk("write{en,addr,data,cycle}", 64'({ram_en, ram_addr, ram_wdata, 32'(cyc)}), 64'({1'b1, e_w.a, e_w.d, 32'(e_w.c)}));
                end
            end
            if (wq.size() != 0 && cyc > wq[0].c) begin
                chk("write_missing_cycle", 64'(cyc), 64'(wq[0].c));
                void'(wq.pop_front());
            end
            if (frame_done) begin
                if (fq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame_done: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e_c = fq.pop_front();
                    chk("frame_done_cycle", 64'(cyc), 64'(e_c));
                end
            end
            if (fq.size() != 0 && cyc > fq[0]) begin
                chk("frame_done_missing_cycle", 64'(cyc), 64'(fq[0]));
                void'(fq.pop_front());
            end
            if (byte_err) begin
                if (bq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte_err: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e_c = bq.pop_front();
                    chk("byte_err_cycle", 64'(cyc), 64'(e_c));
                end
            end
            if (bq.size() != 0 && cyc > bq[0]) begin
                chk("byte_err_missing_cycle", 64'(cyc), 64'(bq[0]));
                void'(bq.pop_front());
            end
            if (done) begin
                chk("writes_left", 64'(wq.size()), 64'd0);
                chk("frame_done_left", 64'(fq.size()), 64'd0);
                chk("byte_err_left", 64'(bq.size()), 64'd0);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
            if (cyc > 20000) begin
                n_err++;
                $display("FAIL watchdog: cycle %0d, expected end before 20000", cyc);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $fatal(1, "watchdog expired");
            end
        end
        prev_rd  <= rd_req;
        prev_rst <= Reset;
    end

    initial begin
        int s;
        repeat (3) tick();
        Reset = 1'b0;
        // first pixel lands at address 0, two cycles after its low byte
        pixel(ADDR_W'(0), 16'h1234);
        repeat (4) tick();
        // full frame plus wrap
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        for (int i = 0; i < 16; i++) pixel(ADDR_W'(i), 16'(i));
        pixel(ADDR_W'(0), 16'h0011);
        repeat (4) tick();
        // 50-cycle read burst holding one pending pixel
        s = cyc;
        rd_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rd_addr = ADDR_W'(i * 3);
            rx_done = (i == 10 || i == 11);
            rx_data = i == 10 ? 8'hCA : 8'hFE;
            tick();
        end
        rx_done = 1'b0;
        rd_req = 1'b0;
        wq.push_back('{ADDR_W'(1), 16'hCAFE, s + 50});
        repeat (3) tick();
        // two pixels during a read burst: second is dropped
        s = cyc;
        ovf_known = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = ADDR_W'(31 - i);
            rx_done = i < 4;
            rx_data = i < 2 ? 8'h11 : 8'h22;
            tick();
        end
        rx_done = 1'b0;
        rd_req = 1'b0;
        wq.push_back('{ADDR_W'(2), 16'h1111, s + 8});
        exp_ovf = 1'b1;
        ovf_known = 1'b1;
        tick();
        pixel(ADDR_W'(4), 16'h3333);
        repeat (3) tick();
`ifdef UART_FB_TIMEOUT_EN
        s = cyc;
        send(8'hAB);
        bq.push_back(s + TIMEOUT_CYC);
        repeat (104) tick();
        pixel(ADDR_W'(5), 16'h5678);
`else
        send(8'hAB);
        repeat (150) tick();
        s = cyc;
        send(8'h56);
        wq.push_back('{ADDR_W'(5), 16'hAB56, s + 2});
`endif
        repeat (3) tick();
        // addr_clr at wr_addr=7 in LO, together with a byte that must be ignored
        pixel(ADDR_W'(6), 16'h0606);
        send(8'h99);
        repeat (2) tick();
        addr_clr = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h77;
        tick();
        addr_clr = 1'b0;
        rx_done = 1'b0;
        pixel(ADDR_W'(0), 16'hBEEF);
        repeat (3) tick();
        // addr_clr drops a pending pixel blocked by reads
        rd_req = 1'b1;
        send(8'h44);
        send(8'h55);
        tick();
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        rd_req = 1'b0;
        repeat (3) tick();
        pixel(ADDR_W'(0), 16'hD00D);
        repeat (3) tick();
        // Reset with a pending pixel: lost silently, overflow cleared
        ovf_known = 1'b0;
        rd_req = 1'b1;
        send(8'h01);
        send(8'h02);
        tick();
        Reset = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        Reset = 1'b0;
        exp_ovf = 1'b0;
        ovf_known = 1'b1;
        tick();
        pixel(ADDR_W'(0), 16'h4242);
        repeat (5) tick();
        done = 1'b1;
    end
endmodule
